// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction prefetch queue between imem port and decode; optional FETCH_PERF_CNT_EN perf counters
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instrF_valid,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_empty_cycles
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // FIFO storage: instruction and its PC; PC+4 is derived at the head
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];
  // addresses of live (non-discarded) in-flight requests, oldest at tag_rd
  logic [31:0]   tag_pc_q     [MAX_OUT];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d;

  logic req_fire;
  logic resp_take;
  logic push_en;
  logic pop_en;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  // head presentation and request issue; reset forces request low while held
  always_comb begin
    instrF_valid   = (count_q != '0);
    instrF         = instrF_valid ? fifo_instr_q[rd_ptr_q] : NOP;
    PCF            = instrF_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
    PCPlus4F       = instrF_valid ? (fifo_pc_q[rd_ptr_q] + 32'd4) : 32'h0;
    imem_req_addr  = fetch_pc_q;
    imem_req_valid = reset && !PCSrcE
                     && (out_q < OW'(MAX_OUT))
                     && ((32'(count_q) + 32'(out_q)) < DEPTH);
  end

  // next-state: redirect wins over push/pop; stale responses are counted off via discard
  always_comb begin
    req_fire   = imem_req_valid && imem_req_ready;
    resp_take  = imem_resp_valid && (out_q != '0);
    pop_en     = instrF_valid && !StallD;
    push_en    = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    out_d      = out_q;
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;

    if (req_fire) begin
      out_d = out_d + OW'(1);
    end
    if (resp_take) begin
      out_d = out_d - OW'(1);
    end

    if (PCSrcE) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = PCTargetE & 32'hFFFF_FFFC;
      // every request still in flight after this edge belongs to the old path
      discard_d  = out_d;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_inc(tag_wr_q);
      end
      if (resp_take) begin
        if (discard_q != '0) begin
          discard_d = discard_q - OW'(1);
        end else begin
          push_en  = 1'b1;
          tag_rd_d = tag_inc(tag_rd_q);
        end
      end
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      discard_q  <= '0;
      fetch_pc_q <= RESET_PC;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // FIFO and tag storage writes; contents are qualified by count/pointers so no reset
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_instr_q[wr_ptr_q] <= imem_resp_data;
      fifo_pc_q[wr_ptr_q]    <= tag_pc_q[tag_rd_q];
    end
    if (req_fire) begin
      tag_pc_q[tag_wr_q] <= fetch_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_empty_q, perf_empty_d;

  // saturating event counters
  always_comb begin
    perf_redirects_d = perf_redirects_q;
    perf_empty_d     = perf_empty_q;
    if (PCSrcE && (perf_redirects_q != 32'hFFFF_FFFF)) begin
      perf_redirects_d = perf_redirects_q + 32'd1;
    end
    if (!instrF_valid && !StallD && (perf_empty_q != 32'hFFFF_FFFF)) begin
      perf_empty_d = perf_empty_q + 32'd1;
    end
  end

  // counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_redirects_q <= '0;
      perf_empty_q     <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_empty_q     <= perf_empty_d;
    end
  end

  assign perf_redirects    = perf_redirects_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed self-checking bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instrF_valid;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_empty_cycles;
`endif

  int   total;
  int   bad;
  logic auto_mem;

  fetch_prefetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .PCSrcE          (PCSrcE),
    .PCTargetE       (PCTargetE),
    .StallD          (StallD),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instrF_valid    (instrF_valid),
    .instrF          (instrF),
    .PCF             (PCF),
    .PCPlus4F        (PCPlus4F)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  // one clock; the 1-cycle memory answers next cycle for a request that fired this cycle
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    #1;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_resp_valid = fire;
      imem_resp_data  = instr_of(a);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; auto_mem = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; auto_mem = 1'b1;
    @(posedge clk);
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    total++; if (instrF_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid: got %b want 0", instrF_valid); end
    total++; if (instrF !== NOP) begin bad++; $display("FAIL rst_instrF: got %h want %h", instrF, NOP); end
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL rst_PCF: got %h want 0", PCF); end
    total++; if (PCPlus4F !== 32'h0) begin bad++; $display("FAIL rst_PCPlus4F: got %h want 0", PCPlus4F); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rel_req_valid: got %b want 1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rel_req_addr: got %h want 0", imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      total++; if (instrF_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, instrF_valid); end
      total++; if (PCF !== pc) begin bad++; $display("FAIL stream_PCF[%0d]: got %h want %h", i, PCF, pc); end
      total++; if (PCPlus4F !== pc + 32'd4) begin bad++; $display("FAIL stream_PCPlus4F[%0d]: got %h want %h", i, PCPlus4F, pc + 32'd4); end
      total++; if (instrF !== instr_of(pc)) begin bad++; $display("FAIL stream_instrF[%0d]: got %h want %h", i, instrF, instr_of(pc)); end
      total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL stream_req_valid[%0d]: got %b want 1", i, imem_req_valid); end
      tick();
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] pc;
    do_reset();
    StallD = 1'b1;
    repeat (5) tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid: got %b want 0", imem_req_valid); end
    total++; if (instrF_valid !== 1'b1) begin bad++; $display("FAIL full_valid: got %b want 1", instrF_valid); end
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL full_PCF: got %h want 0", PCF); end
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid_hold: got %b want 0", imem_req_valid); end
    StallD = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      pc = 32'(i * 4);
      total++; if (instrF_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d]: got %b want 1", i, instrF_valid); end
      total++; if (PCF !== pc) begin bad++; $display("FAIL drain_PCF[%0d]: got %h want %h", i, PCF, pc); end
      total++; if (instrF !== instr_of(pc)) begin bad++; $display("FAIL drain_instrF[%0d]: got %h want %h", i, instrF, instr_of(pc)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    auto_mem = 1'b0;
    tick();
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_maxout_req: got %b want 0", imem_req_valid); end
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_cycle_req: got %b want 0", imem_req_valid); end
    tick();
    PCSrcE = 1'b0;
    #1;
    total++; if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL redir_addr: got %h want 100", imem_req_addr); end
    total++; if (instrF_valid !== 1'b0) begin bad++; $display("FAIL redir_flushed: got %b want 0", instrF_valid); end
    imem_resp_valid = 1'b1; imem_resp_data = instr_of(32'h0);
    tick();
    imem_resp_data = instr_of(32'h4);
    #1;
    total++; if (instrF_valid !== 1'b0) begin bad++; $display("FAIL redir_drop1: got %b want 0", instrF_valid); end
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL redir_req_valid: got %b want 1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL redir_req_addr: got %h want 100", imem_req_addr); end
    tick();
    imem_resp_data = instr_of(32'h100);
    #1;
    total++; if (instrF_valid !== 1'b0) begin bad++; $display("FAIL redir_drop2: got %b want 0", instrF_valid); end
    tick();
    imem_resp_valid = 1'b0;
    #1;
    total++; if (instrF_valid !== 1'b1) begin bad++; $display("FAIL redir_tgt_valid: got %b want 1", instrF_valid); end
    total++; if (PCF !== 32'h100) begin bad++; $display("FAIL redir_tgt_PCF: got %h want 100", PCF); end
    total++; if (PCPlus4F !== 32'h104) begin bad++; $display("FAIL redir_tgt_PCPlus4F: got %h want 104", PCPlus4F); end
    total++; if (instrF !== instr_of(32'h100)) begin bad++; $display("FAIL redir_tgt_instrF: got %h want %h", instrF, instr_of(32'h100)); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick();
    tick();
    tick();
    total++; if (PCF !== 32'h4) begin bad++; $display("FAIL simul_pre_PCF: got %h want 4", PCF); end
    PCSrcE = 1'b1; PCTargetE = 32'h203;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL simul_req_valid: got %b want 0", imem_req_valid); end
    tick();
    PCSrcE = 1'b0;
    #1;
    total++; if (instrF_valid !== 1'b0) begin bad++; $display("FAIL simul_empty: got %b want 0", instrF_valid); end
    total++; if (instrF !== NOP) begin bad++; $display("FAIL simul_nop: got %h want %h", instrF, NOP); end
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL simul_PCF: got %h want 0", PCF); end
    total++; if (PCPlus4F !== 32'h0) begin bad++; $display("FAIL simul_PCPlus4F: got %h want 0", PCPlus4F); end
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL simul_req_after: got %b want 1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h200) begin bad++; $display("FAIL simul_aligned_addr: got %h want 200", imem_req_addr); end
    tick();
    total++; if (instrF_valid !== 1'b0) begin bad++; $display("FAIL simul_bubble: got %b want 0", instrF_valid); end
    tick();
    total++; if (PCF !== 32'h200) begin bad++; $display("FAIL simul_tgt_PCF: got %h want 200", PCF); end
    total++; if (instrF !== instr_of(32'h200)) begin bad++; $display("FAIL simul_tgt_instrF: got %h want %h", instrF, instr_of(32'h200)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    auto_mem = 1'b0;
    tick();
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    tick();
    PCTargetE = 32'h80; imem_resp_valid = 1'b1; imem_resp_data = instr_of(32'h0);
    tick();
    PCSrcE = 1'b0; imem_resp_data = instr_of(32'h4);
    #1;
    total++; if (imem_req_addr !== 32'h80) begin bad++; $display("FAIL b2b_addr: got %h want 80", imem_req_addr); end
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL b2b_req_valid: got %b want 1", imem_req_valid); end
    total++; if (instrF_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", instrF_valid); end
    tick();
    imem_resp_data = instr_of(32'h80);
    #1;
    total++; if (instrF_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop: got %b want 0", instrF_valid); end
    tick();
    imem_resp_valid = 1'b0;
    #1;
    total++; if (PCF !== 32'h80) begin bad++; $display("FAIL b2b_tgt_PCF: got %h want 80", PCF); end
    total++; if (instrF !== instr_of(32'h80)) begin bad++; $display("FAIL b2b_tgt_instrF: got %h want %h", instrF, instr_of(32'h80)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    tick();
    tick();
    total++; if (instrF_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid: got %b want 1", instrF_valid); end
    #1;
    reset = 1'b0; imem_resp_valid = 1'b0;
    #1;
    total++; if (instrF_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", instrF_valid); end
    total++; if (instrF !== NOP) begin bad++; $display("FAIL arst_instrF: got %h want %h", instrF, NOP); end
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL arst_PCF: got %h want 0", PCF); end
    total++; if (PCPlus4F !== 32'h0) begin bad++; $display("FAIL arst_PCPlus4F: got %h want 0", PCPlus4F); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL arst_req_valid: got %b want 0", imem_req_valid); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL arst_rel_req: got %b want 1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL arst_rel_addr: got %h want 0", imem_req_addr); end
    tick();
    tick();
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL arst_first_PCF: got %h want 0", PCF); end
    total++; if (instrF_valid !== 1'b1) begin bad++; $display("FAIL arst_first_valid: got %b want 1", instrF_valid); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_counters();
    do_reset();
    auto_mem = 1'b0; imem_req_ready = 1'b0; StallD = 1'b1;
    #1;
    total++; if (perf_redirects !== 32'h0) begin bad++; $display("FAIL perf_redir_rst: got %0d want 0", perf_redirects); end
    total++; if (perf_empty_cycles !== 32'h0) begin bad++; $display("FAIL perf_empty_rst: got %0d want 0", perf_empty_cycles); end
    tick();
    tick();
    StallD = 1'b0;
    repeat (5) tick();
    StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h40;
    repeat (3) tick();
    PCSrcE = 1'b0;
    tick();
    total++; if (perf_redirects !== 32'd3) begin bad++; $display("FAIL perf_redirects: got %0d want 3", perf_redirects); end
    total++; if (perf_empty_cycles !== 32'd5) begin bad++; $display("FAIL perf_empty_cycles: got %0d want 5", perf_empty_cycles); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect();
    test_simultaneous();
    test_back_to_back();
    test_async_reset();
`ifdef FETCH_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
